// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: request fields in, encoded
// instruction plus statistics counters out.
interface imm_encoder_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_fmt;
  logic [63:0]      in_imm;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_fmt, in_imm, in_rd, in_rs1, in_rs2, in_funct3, out_ready,
    input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_imm, in_rd, in_rs1, in_rs2, in_funct3, out_ready,
    output in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs LOAD/STORE/BRANCH/JAL fields into a 32-bit RV64 instruction word through a
// two-stage valid/ready pipeline, flagging out-of-range or misaligned immediates.
module imm_encoder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  imm_encoder_if.slave bus
);

  localparam logic [1:0] FMT_LOAD   = 2'd0;
  localparam logic [1:0] FMT_STORE  = 2'd1;
  localparam logic [1:0] FMT_BRANCH = 2'd2;
  localparam logic [1:0] FMT_JAL    = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic             r_s1_valid;
  logic [31:0]      r_s1_instr;
  logic             r_s1_err;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_enc_count;
  logic [ERR_W-1:0] r_err_count;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_accept;
  logic               w_deliver;
  logic [31:0]        w_instr;
  logic               w_err;
  logic signed [63:0] w_imm;

  assign w_imm     = $signed(bus.in_imm);
  assign w_adv2    = !r_out_valid || bus.out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign w_accept  = bus.in_valid && w_adv1;
  assign w_deliver = r_out_valid && bus.out_ready;

  // Field placement and range/alignment check; ignored inputs never reach w_instr.
  always_comb begin
    w_instr = '0;
    w_err   = 1'b0;
    case (bus.in_fmt)
      FMT_LOAD: begin
        w_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
        w_err   = (w_imm < -64'sd2048) || (w_imm > 64'sd2047);
      end
      FMT_STORE: begin
        w_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:0], OP_STORE};
        w_err   = (w_imm < -64'sd2048) || (w_imm > 64'sd2047);
      end
      FMT_BRANCH: begin
        w_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                   bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
        w_err   = (w_imm < -64'sd4096) || (w_imm > 64'sd4094) || bus.in_imm[0];
      end
      FMT_JAL: begin
        w_instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                   bus.in_imm[19:12], bus.in_rd, OP_JAL};
        w_err   = (w_imm < -64'sd1048576) || (w_imm > 64'sd1048574) || bus.in_imm[0];
      end
      default: begin
        w_instr = '0;
        w_err   = 1'b0;
      end
    endcase
  end

  // Stage 1: captured encoding and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_instr <= w_instr;
        r_s1_err   <= w_err;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr <= r_s1_instr;
        r_out_err   <= r_s1_err;
      end
    end
  end

  // Delivery statistics: enc_count wraps, err_count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_deliver) begin
      r_enc_count <= r_enc_count + CNT_W'(1);
      if (r_out_err && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_err   = r_out_err;
  assign bus.enc_count = r_enc_count;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, error flags, backpressure, async reset,
// and err_count saturation on a narrow-counter instance.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  imm_encoder_if #(.CNT_W(16), .ERR_W(8)) bus  ();
  imm_encoder_if #(.CNT_W(16), .ERR_W(2)) bus2 ();

  imm_encoder #(.CNT_W(16), .ERR_W(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  imm_encoder #(.CNT_W(16), .ERR_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] fmt, input logic [63:0] imm, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_imm    = imm;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'd1, 64'd16,       5'd31, 5'd2,  5'd6,  3'd3, 32'h00613823, 1'b0};
    vecs[1] = '{2'd2, 64'd8,        5'd0,  5'd1,  5'd2,  3'd0, 32'h00208463, 1'b0};
    vecs[2] = '{2'd3, -64'sd4,      5'd0,  5'd31, 5'd31, 3'd7, 32'hFFDFF06F, 1'b0};
    vecs[3] = '{2'd3, 64'd1048576,  5'd0,  5'd0,  5'd0,  3'd0, 32'h8000006F, 1'b1};
    vecs[4] = '{2'd2, 64'd5,        5'd0,  5'd0,  5'd0,  3'd0, 32'h00000263, 1'b1};
    vecs[5] = '{2'd0, 64'd2048,     5'd0,  5'd0,  5'd0,  3'd0, 32'h80000003, 1'b1};
    vecs[6] = '{2'd0, 64'd2047,     5'd0,  5'd0,  5'd0,  3'd0, 32'h7FF00003, 1'b0};

    rst_n = 1'b0;
    drv(2'd0, 64'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_fmt    = 2'd0;
    bus2.in_imm    = 64'd0;
    bus2.in_rd     = 5'd0;
    bus2.in_rs1    = 5'd0;
    bus2.in_rs2    = 5'd0;
    bus2.in_funct3 = 3'd0;
    bus2.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_err",   64'(bus.out_err),   64'd0);
    chk("rst_enc_count", 64'(bus.enc_count), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    #3 rst_n = 1'b1;
    tick();

    // Single LOAD: two-cycle latency
    drv(2'd0, -64'sd4, 5'd5, 5'd2, 5'd0, 3'd3);
    tick();
    bus.in_valid = 1'b0;
    chk("load_lat1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("load_valid", 64'(bus.out_valid), 64'd1);
    chk("load_instr", 64'(bus.out_instr), 64'hFFC13283);
    chk("load_err",   64'(bus.out_err),   64'd0);
    tick();
    chk("load_drained", 64'(bus.out_valid), 64'd0);
    chk("load_enc_count", 64'(bus.enc_count), 64'd1);

    // Back-to-back stream at full throughput
    for (int i = 0; i < 7; i++) begin
      drv(vecs[i].fmt, vecs[i].imm, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3);
      chk($sformatf("b2b_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
      if (i >= 1) begin
        chk($sformatf("b2b_valid_%0d", i - 1), 64'(bus.out_valid), 64'd1);
        chk($sformatf("b2b_instr_%0d", i - 1), 64'(bus.out_instr), 64'(vecs[i-1].instr));
        chk($sformatf("b2b_err_%0d", i - 1),   64'(bus.out_err),   64'(vecs[i-1].err));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_valid_6", 64'(bus.out_valid), 64'd1);
    chk("b2b_instr_6", 64'(bus.out_instr), 64'h7FF00003);
    chk("b2b_err_6",   64'(bus.out_err),   64'd0);
    tick();
    chk("b2b_drained",   64'(bus.out_valid), 64'd0);
    chk("b2b_enc_count", 64'(bus.enc_count), 64'd8);
    chk("b2b_err_count", 64'(bus.err_count), 64'd3);

    // Backpressure: only two requests fit while the consumer stalls
    bus.out_ready = 1'b0;
    drv(2'd0, 64'd0, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("bp_ready_0", 64'(bus.in_ready), 64'd1);
    tick();
    drv(2'd0, 64'd0, 5'd2, 5'd0, 5'd0, 3'd0);
    chk("bp_ready_1", 64'(bus.in_ready), 64'd1);
    tick();
    drv(2'd0, 64'd0, 5'd3, 5'd0, 5'd0, 3'd0);
    chk("bp_ready_full", 64'(bus.in_ready), 64'd0);
    chk("bp_instr_a",    64'(bus.out_instr), 64'h00000083);
    tick();
    chk("bp_ready_still", 64'(bus.in_ready), 64'd0);
    chk("bp_instr_b",     64'(bus.out_instr), 64'h00000083);
    chk("bp_valid_held",  64'(bus.out_valid), 64'd1);
    tick();
    chk("bp_instr_c",     64'(bus.out_instr), 64'h00000083);
    chk("bp_enc_hold",    64'(bus.enc_count), 64'd8);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_out_2", 64'(bus.out_instr), 64'h00000103);
    drv(2'd0, 64'd0, 5'd4, 5'd0, 5'd0, 3'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out_3", 64'(bus.out_instr), 64'h00000183);
    tick();
    chk("bp_out_4",   64'(bus.out_instr), 64'h00000203);
    chk("bp_valid_4", 64'(bus.out_valid), 64'd1);
    tick();
    chk("bp_drained",   64'(bus.out_valid), 64'd0);
    chk("bp_enc_count", 64'(bus.enc_count), 64'd12);

    // Asynchronous reset with both stages occupied
    bus.out_ready = 1'b0;
    drv(2'd0, 64'd0, 5'd7, 5'd0, 5'd0, 3'd0);
    tick();
    drv(2'd0, 64'd0, 5'd8, 5'd0, 5'd0, 3'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_full", 64'(bus.in_ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_out_instr", 64'(bus.out_instr), 64'd0);
    chk("ar_out_err",   64'(bus.out_err),   64'd0);
    chk("ar_enc_count", 64'(bus.enc_count), 64'd0);
    chk("ar_err_count", 64'(bus.err_count), 64'd0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_in_ready",  64'(bus.in_ready),  64'd1);
    chk("ar_no_replay", 64'(bus.out_valid), 64'd0);
    drv(2'd3, -64'sd4, 5'd1, 5'd0, 5'd0, 3'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("ar_jal_valid", 64'(bus.out_valid), 64'd1);
    chk("ar_jal_instr", 64'(bus.out_instr), 64'hFFDFF0EF);
    chk("ar_jal_err",   64'(bus.out_err),   64'd0);
    tick();
    chk("ar_enc_count_after", 64'(bus.enc_count), 64'd1);

    // Narrow err_count saturates at 3 after five errored deliveries
    bus2.in_fmt   = 2'd0;
    bus2.in_imm   = 64'd4096;
    bus2.in_valid = 1'b1;
    repeat (5) tick();
    bus2.in_valid = 1'b0;
    chk("sat_err_mid", 64'(bus2.err_count), 64'd3);
    chk("sat_out_err", 64'(bus2.out_err),   64'd1);
    tick();
    tick();
    chk("sat_enc_count", 64'(bus2.enc_count), 64'd5);
    chk("sat_err_count", 64'(bus2.err_count), 64'd3);
    chk("sat_drained",   64'(bus2.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
